// File: rtl/module_seg7_if.sv
// ============================================================================
// Module   : module_seg7_if
// Brief    : Data bits and the fourteen segment lines of the two-digit display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface module_seg7_if;
    logic A, B, C, D;
    logic au, bu, cu, du, eu, fu, gu;
    logic ad, bd, cd, dd, ed, fd, gd;

    modport master (
        output A, B, C, D,
        input  au, bu, cu, du, eu, fu, gu,
        input  ad, bd, cd, dd, ed, fd, gd
    );

    modport slave (
        input  A, B, C, D,
        output au, bu, cu, du, eu, fu, gu,
        output ad, bd, cd, dd, ed, fd, gd
    );
endinterface

`default_nettype wire

// File: rtl/module_seg7.sv
// ============================================================================
// Module   : module_seg7
// Brief    : 4-bit value to registered two-digit decimal 7-segment drive.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_seg7 #(
    parameter bit SEG_ACTIVE_LOW     = 1'b0,
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input wire           clk,
    input wire           rst_n,
    module_seg7_if.slave seg
);

    localparam logic [6:0] c_DARK     = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0] c_PAT_ZERO = 7'b1111110;
    localparam logic [6:0] c_PAT_ONE  = 7'b0110000;
    localparam logic [3:0] c_TEN      = 4'd10;

    // Segment order within each pattern is abcdefg, a in the MSB.
    function automatic logic [6:0] f_digit(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    logic [3:0] w_value;
    logic       w_ge_ten;
    logic [3:0] w_units_digit;
    logic [6:0] w_tens_pat;
    logic [6:0] w_units_seg;
    logic [6:0] w_tens_seg;
    logic [6:0] r_units;
    logic [6:0] r_tens;

    assign w_value       = {seg.A, seg.B, seg.C, seg.D};
    assign w_ge_ten      = (w_value >= c_TEN);
    assign w_units_digit = w_ge_ten ? (w_value - c_TEN) : w_value;

    always_comb begin
        w_tens_pat = c_PAT_ZERO;
        if (w_ge_ten) begin
            w_tens_pat = c_PAT_ONE;
        end else if (BLANK_LEADING_ZERO) begin
            w_tens_pat = 7'b0000000;
        end
    end

    assign w_units_seg = f_digit(w_units_digit) ^ c_DARK;
    assign w_tens_seg  = w_tens_pat ^ c_DARK;

    // Output flops keep the pins glitch-free between edges; reset blanks them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_units <= c_DARK;
            r_tens  <= c_DARK;
        end else begin
            r_units <= w_units_seg;
            r_tens  <= w_tens_seg;
        end
    end

    assign {seg.au, seg.bu, seg.cu, seg.du, seg.eu, seg.fu, seg.gu} = r_units;
    assign {seg.ad, seg.bd, seg.cd, seg.dd, seg.ed, seg.fd, seg.gd} = r_tens;

endmodule

`default_nettype wire

// File: tb/tb_module_seg7.sv
// Scoreboard bench for module_seg7: two instances (default polarity, and
// active-low with blanked leading zero) checked against a decimal-digit model.
`default_nettype none

module tb_module_seg7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    module_seg7_if if0 ();
    module_seg7_if if1 ();

    module_seg7 #(
        .SEG_ACTIVE_LOW     (1'b0),
        .BLANK_LEADING_ZERO (1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (if0.slave)
    );

    module_seg7 #(
        .SEG_ACTIVE_LOW     (1'b1),
        .BLANK_LEADING_ZERO (1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (if1.slave)
    );

    typedef struct {
        int         v;
        logic [13:0] exp0;
        logic [13:0] exp1;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Patterns abcdefg, 1 = lit, indexed by decimal digit.
    logic [6:0] digit_tbl [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    // Returns {tens abcdefg, units abcdefg} as they should appear on the pins.
    function automatic logic [13:0] model(input int v, input bit active_low, input bit blank);
        int         tens_digit;
        int         units_digit;
        logic [6:0] t;
        logic [6:0] u;
        tens_digit  = v / 10;
        units_digit = v % 10;
        u = digit_tbl[units_digit];
        if (tens_digit == 0 && blank) t = 7'b0000000;
        else                          t = digit_tbl[tens_digit];
        if (active_low) begin
            t = ~t;
            u = ~u;
        end
        return {t, u};
    endfunction

    function automatic logic [13:0] read0();
        return {if0.ad, if0.bd, if0.cd, if0.dd, if0.ed, if0.fd, if0.gd,
                if0.au, if0.bu, if0.cu, if0.du, if0.eu, if0.fu, if0.gu};
    endfunction

    function automatic logic [13:0] read1();
        return {if1.ad, if1.bd, if1.cd, if1.dd, if1.ed, if1.fd, if1.gd,
                if1.au, if1.bu, if1.cu, if1.du, if1.eu, if1.fu, if1.gu};
    endfunction

    task automatic check(input string name, input int v, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s v=%0d actual tens/units=%b_%b required=%b_%b",
                     name, v, act[13:7], act[6:0], exp[13:7], exp[6:0]);
        end
    endtask

    task automatic set_inputs(input int v);
        logic [3:0] b;
        b = v[3:0];
        {if0.A, if0.B, if0.C, if0.D} = b;
        {if1.A, if1.B, if1.C, if1.D} = b;
    endtask

    // Drive a value between edges (after a throwaway glitch value) and queue what
    // the following rising edge must show.
    task automatic drive(input int v);
        exp_t e;
        @(negedge clk);
        set_inputs(int'($urandom_range(0, 15)));
        #2;
        set_inputs(v);
        e.v    = v;
        e.exp0 = model(v, 1'b0, 1'b0);
        e.exp1 = model(v, 1'b1, 1'b1);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: each edge presents a new value; compare it with the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("seg_hi", e.v, read0(), e.exp0);
                check("seg_lo_blank", e.v, read1(), e.exp1);
            end
        end
    end

    initial begin
        set_inputs(15);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_dark_hi", 15, read0(), 14'h0000);
        check("reset_dark_lo", 15, read1(), 14'h3fff);

        @(negedge clk);
        rst_n = 1'b1;
        drive(15);
        drain();

        drive(0);
        drive(6);
        drive(10);
        drive(12);

        for (int v = 0; v < 16; v++) drive(v);
        for (int v = 15; v >= 0; v--) drive(v);
        for (int i = 0; i < 40; i++) drive(int'($urandom_range(0, 15)));
        drain();

        // Mid-operation reset blanks immediately and holds across an edge.
        drive(8);
        drain();
        rst_n = 1'b0;
        #1;
        check("midreset_dark_hi", 8, read0(), 14'h0000);
        check("midreset_dark_lo", 8, read1(), 14'h3fff);
        @(posedge clk);
        #1;
        check("held_dark_hi", 8, read0(), 14'h0000);
        check("held_dark_lo", 8, read1(), 14'h3fff);
        @(negedge clk);
        rst_n = 1'b1;
        drive(13);
        drive(3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/module_seg7.md
Name: module_seg7

Overview:
- Converts a 4-bit binary value {A,B,C,D} (A = MSB) in the range 0..15 into two decimal digits.
- Drives two 7-segment displays: units (au..gu) and tens (ad..gd).
- Sits at the display stage of the Hamming decoder path on the Tang 9K board, after the corrected data word is available.
- Outputs are registered.

Parameters:
- SEG_ACTIVE_LOW, 0, when 1 every segment output is inverted (0 = lit) for common-anode displays; when 0, 1 = lit.
- BLANK_LEADING_ZERO, 0, when 1 the tens display is fully dark for values 0..9; when 0 it shows "0".

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  1  data bit 3 (MSB)
- B  input  1  data bit 2
- C  input  1  data bit 1
- D  input  1  data bit 0 (LSB)
- au,bu,cu,du,eu,fu,gu  output  1 each  units-digit segments a..g
- ad,bd,cd,dd,ed,fd,gd  output  1 each  tens-digit segments a..g

Behaviour:
- Segment naming is standard: a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle.
- Value: v = {A,B,C,D}, unsigned 0..15.
  - tens = 1 if v >= 10, else 0.
  - units = v - 10 if v >= 10, else v.
- Digit patterns, listed as abcdefg with 1 = lit before polarity:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- Tens display uses only the patterns for 0 and 1. With BLANK_LEADING_ZERO=1 and tens=0, the tens pattern is 0000000.
- Polarity: the final pattern is XORed with SEG_ACTIVE_LOW, for all 14 outputs.
- Timing:
  - Decode is combinational from A..D.
  - All 14 outputs are captured in flops on the rising edge of clk.
  - Latency is 1 cycle: inputs stable before edge N appear on the outputs after edge N.
  - Outputs are glitch-free between edges.
- Reset: rst_n low immediately (asynchronously) forces all segments to the dark level, i.e. 0 when SEG_ACTIVE_LOW=0 and 1 when SEG_ACTIVE_LOW=1.
  - Outputs stay dark while rst_n is low.
  - On release, the first rising edge loads the decode of the current inputs.
  - Reset asserted mid-operation discards the displayed value immediately.
- No handshake. Inputs are sampled every cycle. Input changes between edges have no effect until the next edge.
- Every input combination 0..15 is valid; there are no illegal codes.

Test Plan:
- Reset: rst_n=0 with A..D=1111 -> all 14 outputs 0 (SEG_ACTIVE_LOW=0) without waiting for a clock edge. After release and one edge -> tens 0110000, units 1011011 (15).
- A..D=0000 -> after one edge: tens abcdefg=1111110, units 1111110 ("00").
- A..D=0110 (6) -> after one edge: tens 1111110, units 1011111 ("06").
- A..D=1010 (10) -> tens 0110000, units 1111110 ("10").
- A..D=1100 (12) -> tens 0110000, units 1101101 ("12").
- Exhaustive sweep 0..15 with SEG_ACTIVE_LOW=1 and BLANK_LEADING_ZERO=1:
  - Every output is the inverse of the table above.
  - Tens reads 1111111 for v<=9.
  - Each output updates exactly one edge after its input change.
